// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg: shared FSM states, default widths and measurement record type
package pulse_meter_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int DROP_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, MEAS, HOLD} state_t;
  typedef struct packed {
    logic [CNT_W_DEF-1:0] width;
    logic level;
    logic sat;
  } rec_t;
endpackage

// File: rtl/pulse_width_meter_if.sv
// pulse_width_meter_if: measurement record handshake plus drop reporting
interface pulse_width_meter_if
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DROP_W = DROP_W_DEF
);
  logic meas_valid;
  logic meas_ready;
  logic [CNT_W-1:0] meas_width;
  logic meas_level;
  logic meas_sat;
  logic overrun;
  logic [DROP_W-1:0] drop_cnt;
  modport master(output meas_valid, meas_width, meas_level, meas_sat, overrun, drop_cnt, input meas_ready);
  modport slave(input meas_valid, meas_width, meas_level, meas_sat, overrun, drop_cnt, output meas_ready);
endinterface

// File: rtl/pulse_meter_outreg.sv
// pulse_meter_outreg: one-entry valid/ready record register that drops new records while blocked
module pulse_meter_outreg
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic in_vld,
  input  logic [CNT_W-1:0] in_width,
  input  logic in_level,
  input  logic in_sat,
  input  logic ready,
  output logic valid,
  output logic [CNT_W-1:0] width,
  output logic level,
  output logic sat,
  output logic overrun,
  output logic [DROP_W-1:0] drop_cnt
);
  logic load;
  assign load = in_vld && (!valid || ready);
  // load when empty or popping, otherwise keep the held record and count the drop
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      width <= '0;
      level <= 1'b0;
      sat <= 1'b0;
      overrun <= 1'b0;
      drop_cnt <= '0;
    end else begin
      overrun <= in_vld && !load;
      if (load) begin
        valid <= 1'b1;
        width <= in_width;
        level <= in_level;
        sat <= in_sat;
      end else if (in_vld) begin
        drop_cnt <= &drop_cnt ? drop_cnt : drop_cnt + DROP_W'(1);
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures each completed level of sig_in in cycles (option: PULSE_METER_TIMEOUT_EN)
module pulse_width_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input logic clock,
  input logic reset,
  input logic sig_in,
  pulse_width_meter_if.master m
);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, state_n;
  logic sig_q, chg, rec_vld, rec_sat;
  logic [CNT_W-1:0] cnt, cnt_n, rec_width;
  assign chg = sig_in != sig_q;
  // state, delayed input and level counter; reset samples sig_in so no edge follows reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sig_q <= sig_in;
      cnt <= '0;
    end else begin
      state <= state_n;
      sig_q <= sig_in;
      cnt <= cnt_n;
    end
  end
  // next state, counter update and record emission
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    rec_vld = 1'b0;
    rec_width = cnt;
    rec_sat = cnt == MAX;
    if (state != MEAS) begin
      if (chg) begin
        state_n = MEAS;
        cnt_n = ONE;
      end
    end else if (chg) begin
      rec_vld = 1'b1;
      cnt_n = ONE;
`ifdef PULSE_METER_TIMEOUT_EN
    end else if (cnt == MAX - ONE) begin
      rec_vld = 1'b1;
      rec_width = MAX;
      rec_sat = 1'b1;
      cnt_n = MAX;
      state_n = HOLD;
    end else begin
      cnt_n = cnt + ONE;
`else
    end else begin
      cnt_n = rec_sat ? cnt : cnt + ONE;
`endif
    end
  end
  pulse_meter_outreg #(.CNT_W(CNT_W), .DROP_W(DROP_W)) u_outreg (
    .clock(clock),
    .reset(reset),
    .in_vld(rec_vld),
    .in_width(rec_width),
    .in_level(sig_q),
    .in_sat(rec_sat),
    .ready(m.meas_ready),
    .valid(m.meas_valid),
    .width(m.meas_width),
    .level(m.meas_level),
    .sat(m.meas_sat),
    .overrun(m.overrun),
    .drop_cnt(m.drop_cnt)
  );
endmodule

// File: tb/tb_pulse_width_meter.sv
// tb_pulse_width_meter: table vectors plus scoreboard for the default and a 4-bit counter instance
module tb_pulse_width_meter;
  import pulse_meter_pkg::*;
  typedef struct {bit lvl; int len; int exp_w;} vec_t;
  logic clock = 0, reset = 1, sig0 = 0, sig1 = 0;
  int errors = 0, checks = 0, vcnt0 = 0, ovf0 = 0;
  rec_t q0[$], q1[$];
  rec_t r0, r1;
  vec_t tbl[26];
  always #5 clock = ~clock;
  pulse_width_meter_if #(.CNT_W(16), .DROP_W(8)) b0();
  pulse_width_meter_if #(.CNT_W(4), .DROP_W(8)) b1();
  pulse_width_meter #(.CNT_W(16), .DROP_W(8)) u0(.clock(clock), .reset(reset), .sig_in(sig0), .m(b0.master));
  pulse_width_meter #(.CNT_W(4), .DROP_W(8)) u1(.clock(clock), .reset(reset), .sig_in(sig1), .m(b1.master));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input int w, input bit l, input bit s);
    rec_t r;
    r.width = 16'(w);
    r.level = l;
    r.sat = s;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic seg(input bit l, input int n);
    sig0 = l;
    tick(n);
  endtask

  task automatic do_reset;
    reset = 1;
    tick(1);
    reset = 0;
  endtask

  always @(negedge clock) begin
    if (b0.meas_valid) vcnt0++;
    if (b0.overrun) ovf0++;
    if (b0.meas_valid && b0.meas_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rec0: got width %0d level %0d, expected no record", b0.meas_width, b0.meas_level);
      end else begin
        r0 = q0.pop_front();
        chk("rec0_width", b0.meas_width, r0.width);
        chk("rec0_level", b0.meas_level, r0.level);
        chk("rec0_sat", b0.meas_sat, r0.sat);
      end
    end
  end

  always @(negedge clock) begin
    if (b1.meas_valid && b1.meas_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rec1: got width %0d level %0d, expected no record", b1.meas_width, b1.meas_level);
      end else begin
        r1 = q1.pop_front();
        chk("rec1_width", b1.meas_width, r1.width);
        chk("rec1_level", b1.meas_level, r1.level);
        chk("rec1_sat", b1.meas_sat, r1.sat);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 20; i++) tbl[i] = '{(i % 2 == 0), 4, 4};
    tbl[20] = '{1, 1, 1};
    tbl[21] = '{0, 1, 1};
    tbl[22] = '{1, 7, 7};
    tbl[23] = '{0, 2, 2};
    tbl[24] = '{1, 3, 3};
    tbl[25] = '{0, 5, 5};
    b0.meas_ready = 1;
    b1.meas_ready = 1;
    tick(2);
    reset = 0;
    chk("rst_valid0", b0.meas_valid, 0);
    chk("rst_width0", b0.meas_width, 0);
    chk("rst_drop0", b0.drop_cnt, 0);
    chk("rst_overrun0", b0.overrun, 0);
    chk("rst_valid1", b1.meas_valid, 0);
    vcnt0 = 0;
    seg(0, 100);
    chk("t1_valid_cycles", vcnt0, 0);
    chk("t1_drop", b0.drop_cnt, 0);
    q0.push_back(mk(4, 1, 0));
    seg(1, 4);
    chk("t2_no_rec_first_edge", vcnt0, 0);
    sig0 = 0;
    chk("t2_valid_edge_cycle", b0.meas_valid, 0);
    tick(1);
    chk("t2_valid_after_edge", b0.meas_valid, 1);
    chk("t2_width_after_edge", b0.meas_width, 4);
    tick(3);
    chk("t2_records", vcnt0, 1);
    do_reset();
    ovf0 = 0;
    for (int i = 0; i < 26; i++) begin
      if (i > 0) q0.push_back(mk(tbl[i-1].exp_w, tbl[i-1].lvl, 0));
      seg(tbl[i].lvl, tbl[i].len);
    end
    tick(2);
    chk("t3_overrun", ovf0, 0);
    chk("t3_queue_empty", q0.size(), 0);
    do_reset();
    ovf0 = 0;
    b0.meas_ready = 0;
    seg(1, 3);
    q0.push_back(mk(3, 1, 0));
    seg(0, 5);
    chk("t4_held_valid", b0.meas_valid, 1);
    chk("t4_held_width", b0.meas_width, 3);
    chk("t4_held_level", b0.meas_level, 1);
    seg(1, 2);
    chk("t4_overrun_pulses", ovf0, 1);
    chk("t4_drop_cnt", b0.drop_cnt, 1);
    chk("t4_width_stable", b0.meas_width, 3);
    b0.meas_ready = 1;
    tick(1);
    chk("t4_valid_fell", b0.meas_valid, 0);
    tick(1);
    chk("t4_queue_empty", q0.size(), 0);
    do_reset();
    sig1 = 1;
    tick(14);
    chk("t5_valid_14", b1.meas_valid, 0);
`ifdef PULSE_METER_TIMEOUT_EN
    q1.push_back(mk(15, 1, 1));
    tick(1);
    chk("t5_timeout_valid", b1.meas_valid, 1);
`else
    tick(1);
    chk("t5_timeout_valid", b1.meas_valid, 0);
`endif
    tick(5);
    sig1 = 0;
`ifndef PULSE_METER_TIMEOUT_EN
    q1.push_back(mk(15, 1, 1));
`endif
    tick(1);
`ifdef PULSE_METER_TIMEOUT_EN
    chk("t5_fall_valid", b1.meas_valid, 0);
`else
    chk("t5_fall_valid", b1.meas_valid, 1);
`endif
    tick(3);
    chk("t5_queue_empty", q1.size(), 0);
    chk("t5_drop", b1.drop_cnt, 0);
    do_reset();
    b0.meas_ready = 0;
    seg(0, 2);
    seg(1, 3);
    chk("t6_held_valid", b0.meas_valid, 1);
    chk("t6_held_width", b0.meas_width, 2);
    reset = 1;
    tick(1);
    reset = 0;
    chk("t6_valid_after_reset", b0.meas_valid, 0);
    b0.meas_ready = 1;
    vcnt0 = 0;
    seg(0, 3);
    chk("t6_no_rec_after_reset", vcnt0, 0);
    q0.push_back(mk(3, 0, 0));
    seg(1, 2);
    chk("t6_queue_empty", q0.size(), 0);
    chk("t6_drop", b0.drop_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
